// File: rtl/eth_tx_arbiter_if.sv
// Bundled per-port source streams and the single MAC-facing stream for eth_tx_arbiter.
// The arbiter takes the master view; sources plus MAC (or a bench) take the slave view.
interface eth_tx_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]    s_tvalid;
  logic [64*NUM_PORTS-1:0] s_tdata;
  logic [8*NUM_PORTS-1:0]  s_tkeep;
  logic [NUM_PORTS-1:0]    s_tlast;
  logic [NUM_PORTS-1:0]    s_tuser;
  logic [NUM_PORTS-1:0]    s_tready;

  logic        m_tvalid;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;

  modport master (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser
  );

  modport slave (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the 10G MAC transmit stream.
// Grants are held for a whole frame; optional forced idle gap after each frame.
//
// state | meaning
// IDLE  | no grant; pick next requester searching from last_grant+1
// XFER  | grant held; granted source wired straight through to the MAC
// GAP   | forced idle after a frame; gap_cnt_q down-counts to 0
module eth_tx_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic                    eth_clk,
  input  logic                    sys_rst,
  eth_tx_arbiter_if.master        bus,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic [32*NUM_PORTS-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  localparam logic [2:0] LAST_RST = 3'(NUM_PORTS - 1);
  localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e                  state_q, state_d;
  logic [2:0]              grant_q, grant_d;
  logic [2:0]              last_grant_q, last_grant_d;
  logic [7:0]              gap_cnt_q, gap_cnt_d;
  logic [32*NUM_PORTS-1:0] frame_cnt_q, frame_cnt_d;

  logic       hi_found, lo_found;
  logic [2:0] hi_pick, lo_pick, pick;
  logic       tlast_done;

  // Descending scan leaves the lowest index in each pick; "hi" only sees ports above last_grant.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.s_tvalid[i]) begin
        lo_found = 1'b1;
        lo_pick  = 3'(i);
        if (3'(i) > last_grant_q) begin
          hi_found = 1'b1;
          hi_pick  = 3'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  always_comb begin
    bus.s_tready = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tdata  = '0;
    bus.m_tkeep  = '0;
    bus.m_tlast  = 1'b0;
    bus.m_tuser  = 1'b0;
    if (state_q == XFER) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (3'(i) == grant_q) begin
          bus.m_tvalid    = bus.s_tvalid[i];
          bus.m_tdata     = bus.s_tdata[64*i +: 64];
          bus.m_tkeep     = bus.s_tkeep[8*i +: 8];
          bus.m_tlast     = bus.s_tlast[i];
          bus.m_tuser     = bus.s_tuser[i];
          bus.s_tready[i] = bus.m_tready;
        end
      end
    end
  end

  assign tlast_done = (state_q == XFER) && bus.m_tvalid && bus.m_tready && bus.m_tlast;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gap_cnt_d    = gap_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (lo_found) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        if (tlast_done) begin
          last_grant_d = grant_q;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (3'(i) == grant_q) begin
              frame_cnt_d[32*i +: 32] = frame_cnt_q[32*i +: 32] + 32'd1;
            end
          end
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge eth_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule
